// File: rtl/serial_word_source.sv
// serial_word_source: accepts WIDTH-bit words on valid/ready and emits them one bit per DIV cycles,
// with a strobe on each bit's first cycle, a last-bit flag, and 0 on the line between words.
module serial_word_source #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_sr, w_sr_n;
    logic [BW-1:0]    r_bit, w_bit_n;
    logic [DW-1:0]    r_div, w_div_n;
    logic             w_shift, w_div_end, w_bit_end, w_xfer;

    assign w_shift    = (r_state == SHIFT);
    assign w_div_end  = (r_div == DIV_MAX);
    assign w_bit_end  = (r_bit == BIT_MAX);
    // Ready reopens only on the very last cycle of a word so back-to-back words have no gap
    assign din_ready  = !rst && (!w_shift || (w_bit_end && w_div_end));
    assign w_xfer     = din_valid && din_ready;
    assign busy       = w_shift;
    assign sout       = w_shift && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
    assign sout_valid = w_shift && (r_div == '0);
    assign last       = w_shift && w_bit_end;

    always_comb begin
        w_state_n = r_state;
        w_sr_n    = r_sr;
        w_bit_n   = r_bit;
        w_div_n   = r_div;
        if (w_xfer) begin
            w_state_n = SHIFT;
            w_sr_n    = din;
            w_bit_n   = '0;
            w_div_n   = '0;
        end else if (w_shift) begin
            w_div_n = w_div_end ? '0 : r_div + 1'b1;
            if (w_div_end) begin
                w_sr_n    = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                w_bit_n   = w_bit_end ? '0 : r_bit + 1'b1;
                w_state_n = w_bit_end ? IDLE : SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_n;
            r_sr    <= w_sr_n;
            r_bit   <= w_bit_n;
            r_div   <= w_div_n;
        end
    end
endmodule

// File: tb/tb_serial_word_source.sv
// tb_serial_word_source: directed and randomized checks of three serial_word_source configurations
// (MSB-first DIV=1, MSB-first DIV=3, LSB-first DIV=1) against a cycle-offset reference model.
module tb_serial_word_source;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [3];
    logic [2:0] din_valid;
    logic [2:0] din_ready, sout, sout_valid, last, busy;
    int         checks = 0;
    int         errors = 0;
    int         pos [3] = '{-1, -1, -1};
    logic [7:0] word [3];

    always #5 clk = ~clk;

    serial_word_source #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .sout(sout[0]), .sout_valid(sout_valid[0]), .last(last[0]), .busy(busy[0]));

    serial_word_source #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) u_div3 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .sout(sout[1]), .sout_valid(sout_valid[1]), .last(last[1]), .busy(busy[1]));

    serial_word_source #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .sout(sout[2]), .sout_valid(sout_valid[2]), .last(last[2]), .busy(busy[2]));

    function automatic int dvf(int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic bit msbf(int i);
        return i != 2;
    endfunction

    function automatic logic e_ready(int i);
        return !rst && (pos[i] < 0 || pos[i] == 8 * dvf(i) - 1);
    endfunction

    // pos = cycles since the accepting edge minus one; -1 when no word is in flight
    function automatic logic [4:0] e_vec(int i);
        int d, k;
        d = dvf(i);
        if (pos[i] < 0) return {e_ready(i), 4'b0000};
        k = pos[i] / d;
        return {e_ready(i), 1'b1, k == 7, (pos[i] % d) == 0, msbf(i) ? word[i][7-k] : word[i][k]};
    endfunction

    function automatic logic [4:0] g_vec(int i);
        return {din_ready[i], busy[i], last[i], sout_valid[i], sout[i]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) pos[i] <= -1;
            else if (din_valid[i] && e_ready(i)) begin
                pos[i]  <= 0;
                word[i] <= din[i];
            end else if (pos[i] >= 0) pos[i] <= (pos[i] == 8 * dvf(i) - 1) ? -1 : pos[i] + 1;
        end
    end

    task automatic settle();
        din_valid = 3'b000;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (g_vec(i) !== 5'b00000) begin errors++; $display("FAIL reset_state inst%0d: got %b want 00000", i, g_vec(i)); end
        end
        rst = 1'b0;
        din_valid = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (g_vec(i) !== 5'b10000) begin errors++; $display("FAIL reset_idle inst%0d: got %b want 10000", i, g_vec(i)); end
        end
    endtask

    task automatic test_msb_basic();
        logic [7:0] seq;
        logic [4:0] exp;
        seq = 8'b1101_0110;
        settle();
        din[0] = seq;
        din_valid[0] = 1'b1;
        @(negedge clk);
        din_valid[0] = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            exp = 5'b10000;
            if (c <= 8) exp = {c == 8, 1'b1, c == 8, 1'b1, seq[8-c]};
            checks++;
            if (g_vec(0) !== exp) begin errors++; $display("FAIL msb_basic c%0d: got %b want %b", c, g_vec(0), exp); end
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (g_vec(0) !== e_vec(0)) begin errors++; $display("FAIL msb_rand c%0d: got %b want %b", c, g_vec(0), e_vec(0)); end
            din[0] = 8'($urandom);
            din_valid[0] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        settle();
        din[0] = 8'hFF;
        din_valid[0] = 1'b1;
        @(negedge clk);
        din[0] = 8'h00;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            exp = (c == 17) ? 5'b10000 : {c == 8 || c == 16, 1'b1, c == 8 || c == 16, 1'b1, c <= 8};
            checks++;
            if (g_vec(0) !== exp) begin errors++; $display("FAIL back_to_back c%0d: got %b want %b", c, g_vec(0), exp); end
            if (c == 9) din_valid[0] = 1'b0;
        end
    endtask

    task automatic test_divide();
        logic [7:0] a;
        logic [4:0] exp;
        int k;
        a = 8'hA5;
        settle();
        din[1] = a;
        din_valid[1] = 1'b1;
        @(negedge clk);
        din_valid[1] = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            exp = 5'b10000;
            if (c <= 24) begin
                k = (c - 1) / 3;
                exp = {c == 24, 1'b1, k == 7, (c - 1) % 3 == 0, a[7-k]};
            end
            checks++;
            if (g_vec(1) !== exp) begin errors++; $display("FAIL divide c%0d: got %b want %b", c, g_vec(1), exp); end
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (g_vec(1) !== e_vec(1)) begin errors++; $display("FAIL divide_rand c%0d: got %b want %b", c, g_vec(1), e_vec(1)); end
            din[1] = 8'($urandom);
            din_valid[1] = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic test_lsb();
        logic [4:0] exp;
        settle();
        din[2] = 8'h03;
        din_valid[2] = 1'b1;
        @(negedge clk);
        din_valid[2] = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            exp = (c == 9) ? 5'b10000 : {c == 8, 1'b1, c == 8, 1'b1, c <= 2};
            checks++;
            if (g_vec(2) !== exp) begin errors++; $display("FAIL lsb c%0d: got %b want %b", c, g_vec(2), exp); end
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (g_vec(2) !== e_vec(2)) begin errors++; $display("FAIL lsb_rand c%0d: got %b want %b", c, g_vec(2), e_vec(2)); end
            din[2] = 8'($urandom);
            din_valid[2] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic test_mid_reset();
        settle();
        din[0] = 8'hFF;
        din_valid[0] = 1'b1;
        @(negedge clk);
        din_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (g_vec(0) !== 5'b01011) begin errors++; $display("FAIL mid_reset_bit4: got %b want 01011", g_vec(0)); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (g_vec(0) !== 5'b00000) begin errors++; $display("FAIL mid_reset_next: got %b want 00000", g_vec(0)); end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (g_vec(0) !== 5'b10000) begin errors++; $display("FAIL mid_reset_drop c%0d: got %b want 10000", c, g_vec(0)); end
        end
    endtask

    task automatic test_ignored();
        logic [7:0] w, got;
        int nb;
        w = 8'($urandom);
        got = '0;
        nb = 0;
        settle();
        din[1] = w;
        din_valid[1] = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            checks++;
            if (g_vec(1) !== e_vec(1)) begin errors++; $display("FAIL ignored_model c%0d: got %b want %b", c, g_vec(1), e_vec(1)); end
            if (sout_valid[1]) begin
                got = {got[6:0], sout[1]};
                nb++;
            end
            din[1] = 8'($urandom);
            din_valid[1] = (c < 24) && ($urandom_range(0, 1) == 1);
        end
        checks++;
        if (got !== w || nb != 8) begin errors++; $display("FAIL ignored_word: got %h/%0d bits want %h/8 bits", got, nb, w); end
        @(negedge clk);
        rst = 1'b1;
        din_valid = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (g_vec(i) !== 5'b00000) begin errors++; $display("FAIL reset_valid inst%0d: got %b want 00000", i, g_vec(i)); end
        end
        rst = 1'b0;
        din_valid = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (g_vec(i) !== 5'b10000) begin errors++; $display("FAIL reset_no_xfer inst%0d: got %b want 10000", i, g_vec(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_back_to_back();
        test_divide();
        test_lsb();
        test_mid_reset();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
